// File: rtl/dma_mc_copy.sv
// dma_mc_copy: multi-channel DMA copy engine; round-robin job grant, rd/wr go pulses,
// and a one-entry registered stage streaming read words to the write port at 1 word/cycle.
module dma_mc_copy #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_CH     = 4,
    localparam int CW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_CH-1:0]                 ch_go,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]      ch_rd_addr,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]      ch_wr_addr,
    input  logic [NUM_CH*(ADDR_WIDTH+1)-1:0]  ch_size,
    output logic [NUM_CH-1:0]                 ch_busy,
    output logic [NUM_CH-1:0]                 ch_done,
    output logic [CW-1:0]                     active_ch,
    output logic                              rd_go,
    output logic                              wr_go,
    output logic [ADDR_WIDTH-1:0]             rd_addr,
    output logic [ADDR_WIDTH-1:0]             wr_addr,
    output logic [ADDR_WIDTH:0]               rd_size,
    output logic [ADDR_WIDTH:0]               wr_size,
    output logic                              rd_en,
    input  logic [DATA_WIDTH-1:0]             rd_data,
    input  logic                              empty,
    input  logic                              rd_done,
    output logic                              wr_en,
    output logic [DATA_WIDTH-1:0]             wr_data,
    input  logic                              full,
    input  logic                              wr_done
);
    typedef enum logic [2:0] {IDLE, START, XFER, WAIT_DONE, COMPLETE} state_t;
    state_t state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q [NUM_CH];
    logic [ADDR_WIDTH-1:0] dst_q [NUM_CH];
    logic [ADDR_WIDTH:0]   len_q [NUM_CH];
    logic [NUM_CH-1:0]     busy_q;
    logic [CW-1:0]         g_q, rr_q, pick;
    logic [ADDR_WIDTH:0]   rd_cnt, wr_cnt, len;
    logic [DATA_WIDTH-1:0] hold_data;
    logic                  hold_valid;

    assign len = len_q[g_q];

    // only one job runs at a time, so in IDLE every busy channel is still unstarted
    always_comb begin
        pick = rr_q;
        for (int k = NUM_CH - 1; k >= 0; k--)
            if (busy_q[(int'(rr_q) + k) % NUM_CH]) pick = CW'((int'(rr_q) + k) % NUM_CH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = (|busy_q) ? START : IDLE;
            START:     state_d = (len == '0) ? COMPLETE : XFER;
            XFER:      state_d = (wr_cnt == len) ? WAIT_DONE : XFER;
            WAIT_DONE: state_d = (rd_done && wr_done) ? COMPLETE : WAIT_DONE;
            COMPLETE:  state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_go     = (state_q == START) && (len != '0);
        wr_go     = rd_go;
        rd_en     = (state_q == XFER) && !empty && (rd_cnt < len) && (!hold_valid || !full);
        wr_en     = (state_q == XFER) && hold_valid && !full;
        ch_done   = (state_q == COMPLETE) ? (NUM_CH'(1) << g_q) : '0;
        ch_busy   = busy_q;
        active_ch = g_q;
        rd_addr   = src_q[g_q];
        wr_addr   = dst_q[g_q];
        rd_size   = len;
        wr_size   = len;
        wr_data   = hold_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= '0;
            g_q        <= '0;
            rr_q       <= '0;
            rd_cnt     <= '0;
            wr_cnt     <= '0;
            hold_data  <= '0;
            hold_valid <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                src_q[i] <= '0;
                dst_q[i] <= '0;
                len_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                if (ch_go[i] && !busy_q[i]) begin
                    busy_q[i] <= 1'b1;
                    src_q[i]  <= ch_rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    dst_q[i]  <= ch_wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    len_q[i]  <= ch_size[i*(ADDR_WIDTH+1) +: (ADDR_WIDTH+1)];
                end
            if (state_q == IDLE) g_q <= pick;
            if (state_q == COMPLETE) begin
                busy_q[g_q] <= 1'b0;
                rr_q        <= (g_q == CW'(NUM_CH - 1)) ? '0 : g_q + 1'b1;
            end
            if (state_q == START) begin
                rd_cnt <= '0;
                wr_cnt <= '0;
            end else begin
                if (rd_en) rd_cnt <= rd_cnt + 1'b1;
                if (wr_en) wr_cnt <= wr_cnt + 1'b1;
            end
            if (rd_en) hold_data <= rd_data;
            // a simultaneous read refills the stage as the old word leaves
            hold_valid <= (state_q != START) && (rd_en || (hold_valid && !wr_en));
        end
    end
endmodule
